// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU register-file files:
//   rf_state_t     - state of the bulk-clear sequencer
//   CPU_DATA_W     - default register width
//   CPU_NUM_REGS   - default register count
//   addr_in_range  - true when an address selects a real register
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int CPU_DATA_W   = 8;
    localparam int CPU_NUM_REGS = 8;

    // NUM_REGS need not be a power of two, so an ADDR_W-bit address can
    // point past the last register. The address is widened to 32 bits by
    // the caller, which keeps the compare meaningful for every parameter set.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned num_regs);
        return (addr < num_regs);
    endfunction

endpackage

// File: rtl/cpu_regfile_rdport.sv
// ---------------------------------------------------------------------------
// cpu_regfile_rdport
// One registered read port of the register file. It picks the read value
// and captures it when the port is strobed. The value is chosen in this
// order: zero while the clear is busy, zero for an out-of-range address,
// zero for R0 when R0 is hardwired, the write data when the same address
// is being written this cycle and forwarding is enabled, and otherwise the
// stored register.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_busy          clear sequencer active
//   i_rd_en         read strobe; the output holds when low
//   i_rd_addr       read address
//   i_regs          register storage
//   i_wr_accept     a write lands this cycle
//   i_wr_addr       write address
//   i_wr_data       write data
//   o_rd_data       registered read data
// ---------------------------------------------------------------------------
module cpu_regfile_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int ZERO_R0  = 0,
    parameter int FWD_EN   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_busy,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_regs [NUM_REGS],
    input  logic              i_wr_accept,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_rd_next;
    logic [DATA_W-1:0] r_rd_data;

    always_comb begin
        w_rd_next = '0;
        if (i_busy) begin
            w_rd_next = '0;
        end else if (!addr_in_range(32'(i_rd_addr), NUM_REGS)) begin
            w_rd_next = '0;
        end else if ((ZERO_R0 != 0) && (i_rd_addr == '0)) begin
            w_rd_next = '0;
        end else if ((FWD_EN != 0) && i_wr_accept && (i_wr_addr == i_rd_addr)) begin
            w_rd_next = i_wr_data;
        end else begin
            w_rd_next = i_regs[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_next;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cpu_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// cpu_regfile_2r1w
// CPU general-purpose register file: NUM_REGS x DATA_W, one write port and
// two independent registered read ports. Write data can be forwarded to a
// read of the same address in the same cycle, R0 can be hardwired to zero,
// and a sequencer clears all registers one per cycle on request.
// Ports:
//   i_clk                       clock, all state on the rising edge
//   i_rst_n                     asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data write port
//   i_rd_en_a/i_rd_addr_a       port A read strobe and address
//   o_rd_data_a                 port A data, one cycle after the strobe
//   i_rd_en_b/i_rd_addr_b       port B read strobe and address
//   o_rd_data_b                 port B data, one cycle after the strobe
//   i_clr_req                   start a clear of all registers
//   o_clr_busy                  clear in progress
// ---------------------------------------------------------------------------
module cpu_regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int ZERO_R0  = 0,
    parameter int FWD_EN   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en_a,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic              i_rd_en_b,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_clr_req,
    output logic              o_clr_busy
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    rf_state_t         r_state;
    rf_state_t         w_state_next;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_next;
    logic              r_clr_busy;
    logic              w_wr_accept;
    logic              w_clr_active;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic [NUM_REGS-1:0] w_clr_sel;

    assign w_clr_active = (r_state == RF_CLEAR);

    // Writes are dropped while clearing, and never land outside the array
    // or on a hardwired R0.
    assign w_wr_accept = i_wr_en
                      && addr_in_range(32'(i_wr_addr), NUM_REGS)
                      && !((ZERO_R0 != 0) && (i_wr_addr == '0))
                      && (r_state == RF_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign w_wr_sel[gi]  = w_wr_accept  && (i_wr_addr == ADDR_W'(gi));
            assign w_clr_sel[gi] = w_clr_active && (r_clr_idx == ADDR_W'(gi));
        end
    endgenerate

    // Storage. Clear and write selects never overlap because a write is
    // only accepted in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_clr_sel[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wr_sel[i]) begin
                    r_regs[i] <= i_wr_data;
                end
            end
        end
    end

    // Clear sequencer: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RF_IDLE;
            r_clr_idx  <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_idx  <= w_clr_idx_next;
            r_clr_busy <= (w_state_next == RF_CLEAR);
        end
    end

    // Clear sequencer: next state. One register is cleared per cycle, so a
    // clear occupies exactly NUM_REGS cycles. A request seen while busy is
    // ignored; a request still held on the return to IDLE starts again.
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        case (r_state)
            RF_IDLE: begin
                if (i_clr_req) begin
                    w_state_next   = RF_CLEAR;
                    w_clr_idx_next = '0;
                end
            end
            RF_CLEAR: begin
                if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_next   = RF_IDLE;
                    w_clr_idx_next = '0;
                end else begin
                    w_clr_idx_next = r_clr_idx + 1'b1;
                end
            end
            default: begin
                w_state_next   = RF_IDLE;
                w_clr_idx_next = '0;
            end
        endcase
    end

    assign o_clr_busy = r_clr_busy;

    cpu_regfile_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0),
        .FWD_EN   (FWD_EN),
        .ADDR_W   (ADDR_W)
    ) u_rdport_a (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_busy      (w_clr_active),
        .i_rd_en     (i_rd_en_a),
        .i_rd_addr   (i_rd_addr_a),
        .i_regs      (r_regs),
        .i_wr_accept (w_wr_accept),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_rd_data   (o_rd_data_a)
    );

    cpu_regfile_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0),
        .FWD_EN   (FWD_EN),
        .ADDR_W   (ADDR_W)
    ) u_rdport_b (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_busy      (w_clr_active),
        .i_rd_en     (i_rd_en_b),
        .i_rd_addr   (i_rd_addr_b),
        .i_regs      (r_regs),
        .i_wr_accept (w_wr_accept),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_rd_data   (o_rd_data_b)
    );

endmodule

// File: tb/tb_cpu_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile_2r1w
// Four register files with different parameter sets share one stimulus:
//   u_def  : 8 regs, forwarding on,  R0 writable
//   u_nofw : 8 regs, forwarding off, R0 writable
//   u_zero : 8 regs, forwarding on,  R0 hardwired to zero
//   u_six  : 6 regs, forwarding on,  R0 writable (addresses 6,7 invalid)
// Expected values are written out by hand next to each check.
// ---------------------------------------------------------------------------
module tb_cpu_regfile_2r1w;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_a;
    logic [2:0] rd_addr_a;
    logic       rd_en_b;
    logic [2:0] rd_addr_b;
    logic       clr_req;

    logic [7:0] rda_def, rdb_def, rda_nofw, rdb_nofw;
    logic [7:0] rda_zero, rdb_zero, rda_six, rdb_six;
    logic       busy_def, busy_nofw, busy_zero, busy_six;

    int total = 0;
    int bad   = 0;
    int cnt_def;
    int cnt_six;

    cpu_regfile_2r1w #(.DATA_W(8), .NUM_REGS(8), .ZERO_R0(0), .FWD_EN(1)) u_def (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a), .o_rd_data_a(rda_def),
        .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b), .o_rd_data_b(rdb_def),
        .i_clr_req(clr_req), .o_clr_busy(busy_def)
    );

    cpu_regfile_2r1w #(.DATA_W(8), .NUM_REGS(8), .ZERO_R0(0), .FWD_EN(0)) u_nofw (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a), .o_rd_data_a(rda_nofw),
        .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b), .o_rd_data_b(rdb_nofw),
        .i_clr_req(clr_req), .o_clr_busy(busy_nofw)
    );

    cpu_regfile_2r1w #(.DATA_W(8), .NUM_REGS(8), .ZERO_R0(1), .FWD_EN(1)) u_zero (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a), .o_rd_data_a(rda_zero),
        .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b), .o_rd_data_b(rdb_zero),
        .i_clr_req(clr_req), .o_clr_busy(busy_zero)
    );

    cpu_regfile_2r1w #(.DATA_W(8), .NUM_REGS(6), .ZERO_R0(0), .FWD_EN(1)) u_six (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a), .o_rd_data_a(rda_six),
        .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b), .o_rd_data_b(rdb_six),
        .i_clr_req(clr_req), .o_clr_busy(busy_six)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en_a   = 1'b0;
        rd_addr_a = '0;
        rd_en_b   = 1'b0;
        rd_addr_b = '0;
        clr_req   = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [2:0] b);
        rd_en_a = 1'b1; rd_addr_a = a;
        rd_en_b = 1'b1; rd_addr_b = b;
        tick();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_rda", 32'(rda_def), 32'h0);
        chk("rst_busy", 32'(busy_def), 32'h0);
        rst_n = 1'b1;
        tick();

        // Plain write then read on both ports
        do_write(3'd3, 8'hA5);
        do_read(3'd3, 3'd3);
        chk("wr_rd_def_a",  32'(rda_def),  32'hA5);
        chk("wr_rd_def_b",  32'(rdb_def),  32'hA5);
        chk("wr_rd_nofw_a", 32'(rda_nofw), 32'hA5);
        chk("wr_rd_zero_b", 32'(rdb_zero), 32'hA5);
        chk("wr_rd_six_a",  32'(rda_six),  32'hA5);
        rd_addr_a = 3'd0;
        tick();
        chk("hold_def_a", 32'(rda_def), 32'hA5);

        // Forwarding: R5=11, then write 22 and read R5 in the same cycle
        do_write(3'd5, 8'h11);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h22;
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        tick();
        idle_inputs();
        chk("fwd_def",  32'(rda_def),  32'h22);
        chk("fwd_nofw", 32'(rda_nofw), 32'h11);
        chk("fwd_six",  32'(rda_six),  32'h22);
        do_read(3'd5, 3'd5);
        chk("nofw_landed", 32'(rdb_nofw), 32'h22);

        // Hardwired R0: write FF to R0 with a forwarded read
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        tick();
        idle_inputs();
        chk("r0_zero_fwd", 32'(rda_zero), 32'h0);
        chk("r0_def_fwd",  32'(rda_def),  32'hFF);
        chk("r0_nofw_old", 32'(rda_nofw), 32'h0);
        do_write(3'd1, 8'h77);
        do_read(3'd0, 3'd1);
        chk("r0_zero_rd", 32'(rda_zero), 32'h0);
        chk("r1_zero_rd", 32'(rdb_zero), 32'h77);
        chk("r0_def_rd",  32'(rda_def),  32'hFF);

        // Out-of-range addresses on the 6-register instance
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h99;
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        tick();
        idle_inputs();
        chk("oor_fwd_six", 32'(rda_six), 32'h0);
        chk("oor_fwd_def", 32'(rda_def), 32'h99);
        do_read(3'd3, 3'd7);
        chk("oor_rd_six",  32'(rdb_six), 32'h0);
        chk("six_r3_keep", 32'(rda_six), 32'hA5);
        chk("oor_rd_def",  32'(rdb_def), 32'h99);
        do_write(3'd6, 8'h66);
        do_read(3'd6, 3'd5);
        chk("oor6_six", 32'(rda_six), 32'h0);
        chk("r6_def",   32'(rda_def), 32'h66);
        chk("six_r5",   32'(rdb_six), 32'h22);

        // Bulk clear
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 8'h10 + 8'(i));
        end
        do_read(3'd7, 3'd2);
        chk("fill_r7", 32'(rda_def), 32'h17);
        chk("fill_r2", 32'(rdb_def), 32'h12);

        // Write and forwarded read in the same cycle the request is taken
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hC4;
        rd_en_a = 1'b1; rd_addr_a = 3'd4;
        tick();
        idle_inputs();
        chk("clr_start_busy", 32'(busy_def), 32'h1);
        chk("clr_start_fwd",  32'(rda_def),  32'hC4);
        cnt_def = busy_def ? 1 : 0;
        cnt_six = busy_six ? 1 : 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 1) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hEE;
                rd_en_a = 1'b1; rd_addr_a = 3'd2;
            end
            tick();
            idle_inputs();
            if (cyc == 1) begin
                chk("busy_read", 32'(rda_def), 32'h0);
            end
            if (busy_def) cnt_def++;
            if (busy_six) cnt_six++;
        end
        chk("busy_len_def", 32'(cnt_def), 32'd8);
        chk("busy_len_six", 32'(cnt_six), 32'd6);
        for (int r = 0; r < 8; r++) begin
            do_read(3'(r), 3'(r));
            chk($sformatf("clr_def_r%0d", r),  32'(rda_def),  32'h0);
            chk($sformatf("clr_nofw_r%0d", r), 32'(rdb_nofw), 32'h0);
        end

        // Asynchronous reset in the middle of a clear
        do_write(3'd7, 8'h5A);
        do_read(3'd7, 3'd7);
        chk("pre_arst_r7", 32'(rda_def), 32'h5A);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("midclr_busy", 32'(busy_def), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rda",  32'(rda_def),  32'h0);
        chk("arst_rdb",  32'(rdb_def),  32'h0);
        chk("arst_busy", 32'(busy_def), 32'h0);
        chk("arst_busy_six", 32'(busy_six), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy_def), 32'h0);
        do_write(3'd6, 8'h3C);
        do_read(3'd6, 3'd7);
        chk("post_rst_wr", 32'(rda_def), 32'h3C);
        chk("post_rst_r7", 32'(rdb_def), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
